axil_led_pwm: RTL
=================

# axil_led_pwm

AXI4-Lite slave that drives `NUM_CH` LED outputs, each with an independent PWM duty cycle. It sets brightness per channel, where the earlier block could only switch each LED fully on or off. A shared prescaler and period counter set the PWM frequency. Duty writes are double-buffered so that brightness changes take effect only at a period boundary. The block sits at the top level behind the AXI-Lite interconnect, in the slot the plain LED register block used to occupy.

## Interface
- `NUM_CH`, default 8: number of LED channels, 1..16.
- `PWM_W`, default 8: width of the duty value and the period counter.
- `PRESC_W`, default 16: width of the prescaler.
- `ADDR_W`, default 8: number of decoded address bits. Must be at least 7.
- `clk` in 1: the single clock.
- `rst` in 1: reset, **asynchronous, active-low**.
- `s_axil_awvalid`/`s_axil_awready` in/out 1; `s_axil_awaddr` in `ADDR_W`; `s_axil_awprot` in 3 (ignored).
- `s_axil_wvalid`/`s_axil_wready` in/out 1; `s_axil_wdata` in 32; `s_axil_wstrb` in 4.
- `s_axil_bvalid`/`s_axil_bready` out/in 1; `s_axil_bresp` out 2.
- `s_axil_arvalid`/`s_axil_arready` in/out 1; `s_axil_araddr` in `ADDR_W`; `s_axil_arprot` in 3 (ignored).
- `s_axil_rvalid`/`s_axil_rready` out/in 1; `s_axil_rdata` out 32; `s_axil_rresp` out 2.
- `led` out `NUM_CH`: registered PWM outputs.

## Operation
- **Register map** (addresses are word-aligned; bits [1:0] are ignored):
  - 0x00 `CTRL`, RW: bit0 `EN`, bit1 `INV`.
  - 0x04 `PRESC`, RW, `PRESC_W` bits.
  - 0x08 `CNT`, RO: current period counter.
  - 0x40 + 4·i `DUTY[i]`, RW, `PWM_W` bits, for i < `NUM_CH`.
- **Unmapped addresses:**
  - A write returns resp 2'b10 (SLVERR) and has no effect.
  - A read returns resp SLVERR with rdata 0.
  - A write to `CNT` returns OKAY and has no effect.
  - Unused register bits read as 0.
- **Byte strobes:** `wstrb` byte lanes are honoured for every RW register.
- **Write FSM** (`W_IDLE` → `W_RESP`):
  - In `W_IDLE`, the AW and W channels are accepted independently and latched. `awready` stays high until the address is latched; `wready` stays high until the data is latched.
  - Once both are latched, the register is updated and the FSM moves to `W_RESP` with `bvalid`=1.
  - In `W_RESP`, `bvalid` is held until `bready`, then the FSM returns to `W_IDLE`. `awready` and `wready` are 0 while in `W_RESP`.
- **Read FSM** (`R_IDLE` → `R_DATA`):
  - `arready`=1 in `R_IDLE`. On an accepted address, the FSM registers `rdata` and `rresp` and moves to `R_DATA` with `rvalid`=1.
  - In `R_DATA`, `rvalid` and `rdata` are held until `rready`.
  - The read and write paths are independent and may complete in the same cycle.
- **PWM:**
  - The prescaler counts 0..`PRESC`. When it equals `PRESC`, a `tick` is generated and the prescaler returns to 0.
  - On each `tick`, `CNT` increments and wraps from 2^`PWM_W`−1 to 0.
  - `PRESC`=0 produces a tick every cycle.
- **Duty buffering:** a write to `DUTY[i]` goes to a shadow register. Every active duty is loaded from its shadow on the tick that wraps `CNT` to 0. While `EN`=0, shadows are copied to the active registers every cycle.
- **Output rule:** `led[i]` = `INV` XOR (`EN` AND (`act_duty[i]` == all-ones OR `CNT` < `act_duty[i]`)).
  - Duty 0 gives the LED permanently off.
  - Duty all-ones gives the LED permanently on.
- **Disable:** clearing `EN` holds the prescaler and `CNT` at 0. Setting `EN` restarts counting from 0.

## Timing
- **Reset values:**
  - All ready outputs, `bvalid`, `rvalid`, `bresp`, `rresp` and `rdata` = 0.
  - `CTRL`, `PRESC`, `CNT`, all shadow duties and all active duties = 0.
  - `led` = 0.
- **Ready after reset:** `awready`, `wready` and `arready` go to 1 in the first cycle after `rst` deasserts.
- **Write latency:** when AW and W arrive in the same cycle, `bvalid` rises on the next edge, and the register value is visible from that edge.
- **Read latency:** `rvalid` rises one cycle after the AR handshake.
- **Output latency:** `led` is registered, so it lags its `CNT` and `CTRL` inputs by one cycle.
- **Asserting `rst` mid-transaction** aborts it. No response is issued for the aborted transaction.

## Configuration
- **`AXIL_LED_PWM_IRQ_EN` defined:**
  - Adds an output port `irq` (1 bit, reset value 0).
  - Adds register 0x0C `IRQ`: bit0 `PEND` (write-1-to-clear), bit1 `IE` (RW).
  - `PEND` is set on every `CNT` wrap while `EN`=1.
  - `irq` = `PEND` AND `IE`, registered.
  - If a set event and a clear occur in the same cycle, the set wins.
- **`AXIL_LED_PWM_IRQ_EN` undefined:** there is no `irq` port, and 0x0C decodes as unmapped (SLVERR).

## Structure
- **Package `axil_led_pwm_pkg`:**
  - Register offsets (`CTRL_OFS`, `PRESC_OFS`, `CNT_OFS`, `IRQ_OFS`, `DUTY_BASE`).
  - `CTRL` bit indices.
  - The `resp_e` enum (OKAY = 2'b00, SLVERR = 2'b10).
  - The `wr_state_e` and `rd_state_e` FSM enums.
- **Sub-module `led_pwm_core`:** contains the prescaler, `CNT`, shadow/active duty registers and the output compare. It is parametrised by `NUM_CH`, `PWM_W` and `PRESC_W`.
- **Top level:** contains the AXI-Lite FSMs and the register decode.

## Test plan
- **Reset:** assert `rst`, then release it → all outputs are 0, and the ready outputs are 1 on the following cycle.
- **Basic PWM:** write `PRESC`=0, `DUTY[0]`=0x40, `CTRL`=1 → `led[0]` is high for 64 of every 256 cycles. `DUTY[1]`=0xFF → constantly high; `DUTY[2]`=0 → constantly low.
- **Duty buffering:** change `DUTY[0]` from 0x40 to 0x80 while `CNT`=0x10 → `led[0]` keeps the old pattern until the `CNT` wrap, then shows the new one.
- **Decoupled write channels:** present AW 3 cycles before W, with `bready` held low for 5 cycles → the write is applied once, `bvalid` is held, and `awready` stays 0 while `bvalid` is pending.
- **Error paths and strobes:** read 0x3C → SLVERR, rdata 0. Write 0x12345678 with `wstrb`=4'b0001 to `PRESC` (previously 0xFFFF) → readback 0xFF78.
- **IRQ (`AXIL_LED_PWM_IRQ_EN` defined):** set `IE`, run past a `CNT` wrap → `irq`=1. Write 1 to `PEND` → `irq`=0 on the next cycle.

Source files
------------

// File: rtl/axil_led_pwm_pkg.sv
// Shared register map, response codes and FSM state types for the AXI-Lite LED PWM block.
package axil_led_pwm_pkg;

    localparam logic [7:0] CTRL_OFS  = 8'h00;
    localparam logic [7:0] PRESC_OFS = 8'h04;
    localparam logic [7:0] CNT_OFS   = 8'h08;
    localparam logic [7:0] IRQ_OFS   = 8'h0C;
    localparam logic [7:0] DUTY_BASE = 8'h40;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_INV_BIT = 1;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_e;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

endpackage

// File: rtl/axil_led_pwm_core.sv
// PWM engine: shared prescaler and period counter, double-buffered per-channel duty, registered compare.
module led_pwm_core #(
    parameter int NUM_CH  = 8,
    parameter int PWM_W   = 8,
    parameter int PRESC_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      inv,
    input  logic [PRESC_W-1:0]        presc,
    input  logic [NUM_CH-1:0]         shd_we,
    input  logic [PWM_W-1:0]          shd_wdata,
    output logic [NUM_CH*PWM_W-1:0]   shd_flat,
    output logic [PWM_W-1:0]          cnt,
    output logic                      wrap,
    output logic [NUM_CH-1:0]         led
);

    localparam logic [PWM_W-1:0] ONES = '1;

    logic [PRESC_W-1:0] pre_q, pre_d;
    logic [PWM_W-1:0]   cnt_q, cnt_d;
    logic [NUM_CH-1:0]  led_q, led_d;
    logic [PWM_W-1:0]   shd_q [NUM_CH];
    logic [PWM_W-1:0]   shd_d [NUM_CH];
    logic [PWM_W-1:0]   act_q [NUM_CH];
    logic [PWM_W-1:0]   act_d [NUM_CH];
    logic               tick;

    // >= rather than == so a PRESC lowered below the running count still ticks promptly
    assign tick = en && (pre_q >= presc);
    assign wrap = tick && (cnt_q == ONES);

    always_comb begin
        pre_d = pre_q;
        cnt_d = cnt_q;
        if (!en) begin
            pre_d = '0;
            cnt_d = '0;
        end else if (tick) begin
            pre_d = '0;
            cnt_d = cnt_q + PWM_W'(1);
        end else begin
            pre_d = pre_q + PRESC_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign shd_d[gi] = shd_we[gi] ? shd_wdata : shd_q[gi];
            assign act_d[gi] = (!en || wrap) ? shd_q[gi] : act_q[gi];
            assign led_d[gi] = inv ^ (en && ((act_q[gi] == ONES) || (cnt_q < act_q[gi])));
            assign shd_flat[gi*PWM_W +: PWM_W] = shd_q[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q <= '0;
            cnt_q <= '0;
            led_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                shd_q[i] <= '0;
                act_q[i] <= '0;
            end
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
            led_q <= led_d;
            for (int i = 0; i < NUM_CH; i++) begin
                shd_q[i] <= shd_d[i];
                act_q[i] <= act_d[i];
            end
        end
    end

    assign cnt = cnt_q;
    assign led = led_q;

endmodule

// File: rtl/axil_led_pwm.sv
// AXI4-Lite slave front end for the LED PWM core: write/read FSMs and register decode.
// Optional interrupt register and irq port are built when AXIL_LED_PWM_IRQ_EN is defined.
module axil_led_pwm
    import axil_led_pwm_pkg::*;
#(
    parameter int NUM_CH  = 8,
    parameter int PWM_W   = 8,
    parameter int PRESC_W = 16,
    parameter int ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_axil_awvalid,
    output logic              s_axil_awready,
    input  logic [ADDR_W-1:0] s_axil_awaddr,
    input  logic [2:0]        s_axil_awprot,
    input  logic              s_axil_wvalid,
    output logic              s_axil_wready,
    input  logic [31:0]       s_axil_wdata,
    input  logic [3:0]        s_axil_wstrb,
    output logic              s_axil_bvalid,
    input  logic              s_axil_bready,
    output logic [1:0]        s_axil_bresp,
    input  logic              s_axil_arvalid,
    output logic              s_axil_arready,
    input  logic [ADDR_W-1:0] s_axil_araddr,
    input  logic [2:0]        s_axil_arprot,
    output logic              s_axil_rvalid,
    input  logic              s_axil_rready,
    output logic [31:0]       s_axil_rdata,
    output logic [1:0]        s_axil_rresp,
    output logic [NUM_CH-1:0] led
`ifdef AXIL_LED_PWM_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int CTRL_WI  = int'(CTRL_OFS) / 4;
    localparam int PRESC_WI = int'(PRESC_OFS) / 4;
    localparam int CNT_WI   = int'(CNT_OFS) / 4;
    localparam int DUTY_WI  = int'(DUTY_BASE) / 4;
`ifdef AXIL_LED_PWM_IRQ_EN
    localparam int IRQ_WI   = int'(IRQ_OFS) / 4;
`endif

    wr_state_e          wst_q, wst_d;
    logic               awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    resp_e              bresp_q, bresp_d;
    logic               aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic [ADDR_W-1:0]  awaddr_q, awaddr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         wstrb_q, wstrb_d;

    rd_state_e          rst_q, rst_d;
    logic               arready_q, arready_d, rvalid_q, rvalid_d;
    logic [31:0]        rdata_q, rdata_d;
    resp_e              rresp_q, rresp_d;

    logic [1:0]         ctrl_q, ctrl_d;
    logic [PRESC_W-1:0] presc_q, presc_d;

    logic               aw_hs, w_hs, wr_fire;
    logic [ADDR_W-1:0]  wr_addr;
    logic [31:0]        wr_data, strb_mask;
    logic [3:0]         wr_strb;
    int                 wr_word, rd_word;
    logic               wr_is_ctrl, wr_is_presc, wr_is_cnt, wr_is_duty, wr_is_irq;
    resp_e              wr_resp, rd_resp;
    logic [31:0]        rd_val;

    logic [NUM_CH-1:0]       shd_we;
    logic [PWM_W-1:0]        shd_wdata, duty_old;
    logic [NUM_CH*PWM_W-1:0] shd_flat;
    logic [PWM_W-1:0]        shd_arr [NUM_CH];
    logic [PWM_W-1:0]        cnt;
    logic                    wrap;

    // Write channel: AW and W latch independently; the register update uses whichever copy is live
    assign aw_hs   = s_axil_awvalid && awready_q;
    assign w_hs    = s_axil_wvalid && wready_q;
    assign wr_addr = aw_got_q ? awaddr_q : s_axil_awaddr;
    assign wr_data = w_got_q ? wdata_q : s_axil_wdata;
    assign wr_strb = w_got_q ? wstrb_q : s_axil_wstrb;
    assign wr_word = int'(wr_addr[ADDR_W-1:2]);
    assign rd_word = int'(s_axil_araddr[ADDR_W-1:2]);

    assign wr_is_ctrl  = (wr_word == CTRL_WI);
    assign wr_is_presc = (wr_word == PRESC_WI);
    assign wr_is_cnt   = (wr_word == CNT_WI);
    assign wr_is_duty  = (wr_word >= DUTY_WI) && (wr_word < DUTY_WI + NUM_CH);
`ifdef AXIL_LED_PWM_IRQ_EN
    assign wr_is_irq   = (wr_word == IRQ_WI);
`else
    assign wr_is_irq   = 1'b0;
`endif
    assign wr_resp = (wr_is_ctrl || wr_is_presc || wr_is_cnt || wr_is_duty || wr_is_irq) ? OKAY : SLVERR;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_strb
            assign strb_mask[gi*8 +: 8] = {8{wr_strb[gi]}};
        end
        for (gi = 0; gi < NUM_CH; gi++) begin : g_duty
            assign shd_arr[gi] = shd_flat[gi*PWM_W +: PWM_W];
            assign shd_we[gi]  = wr_fire && (wr_word == DUTY_WI + gi);
        end
    endgenerate

    always_comb begin
        wst_d     = wst_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wr_fire   = 1'b0;
        case (wst_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_got_d = 1'b1;
                    awaddr_d = s_axil_awaddr;
                end
                if (w_hs) begin
                    w_got_d = 1'b1;
                    wdata_d = s_axil_wdata;
                    wstrb_d = s_axil_wstrb;
                end
                if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
                    wr_fire   = 1'b1;
                    wst_d     = W_RESP;
                    bvalid_d  = 1'b1;
                    bresp_d   = wr_resp;
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                end else begin
                    awready_d = !(aw_got_q || aw_hs);
                    wready_d  = !(w_got_q || w_hs);
                end
            end
            W_RESP: begin
                if (s_axil_bready) begin
                    wst_d     = W_IDLE;
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            default: wst_d = W_IDLE;
        endcase
    end

    always_comb begin
        ctrl_d   = ctrl_q;
        presc_d  = presc_q;
        duty_old = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_word == DUTY_WI + i) duty_old = shd_arr[i];
        end
        shd_wdata = (duty_old & ~strb_mask[PWM_W-1:0]) | (wr_data[PWM_W-1:0] & strb_mask[PWM_W-1:0]);
        if (wr_fire && wr_is_ctrl)
            ctrl_d = (ctrl_q & ~strb_mask[1:0]) | (wr_data[1:0] & strb_mask[1:0]);
        if (wr_fire && wr_is_presc)
            presc_d = (presc_q & ~strb_mask[PRESC_W-1:0]) | (wr_data[PRESC_W-1:0] & strb_mask[PRESC_W-1:0]);
    end

`ifdef AXIL_LED_PWM_IRQ_EN
    logic pend_q, pend_d, ie_q, ie_d, irq_q, irq_d;

    // A wrap in the same cycle as a clear must leave PEND set
    always_comb begin
        pend_d = pend_q;
        ie_d   = ie_q;
        if (wr_fire && wr_is_irq && wr_strb[0]) begin
            ie_d = wr_data[1];
            if (wr_data[0]) pend_d = 1'b0;
        end
        if (wrap) pend_d = 1'b1;
        irq_d = pend_d && ie_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= 1'b0;
            ie_q   <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ie_q   <= ie_d;
            irq_q  <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    always_comb begin
        rd_val  = '0;
        rd_resp = OKAY;
        if (rd_word == CTRL_WI) begin
            rd_val = 32'(ctrl_q);
        end else if (rd_word == PRESC_WI) begin
            rd_val = 32'(presc_q);
        end else if (rd_word == CNT_WI) begin
            rd_val = 32'(cnt);
`ifdef AXIL_LED_PWM_IRQ_EN
        end else if (rd_word == IRQ_WI) begin
            rd_val = {30'b0, ie_q, pend_q};
`endif
        end else if ((rd_word >= DUTY_WI) && (rd_word < DUTY_WI + NUM_CH)) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (rd_word == DUTY_WI + i) rd_val = 32'(shd_arr[i]);
            end
        end else begin
            rd_resp = SLVERR;
        end
    end

    always_comb begin
        rst_d     = rst_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (rst_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (s_axil_arvalid && arready_q) begin
                    rst_d     = R_DATA;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = rd_val;
                    rresp_d   = rd_resp;
                end
            end
            R_DATA: begin
                if (s_axil_rready) begin
                    rst_d     = R_IDLE;
                    arready_d = 1'b1;
                    rvalid_d  = 1'b0;
                end
            end
            default: rst_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wst_q     <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rst_q     <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
            ctrl_q    <= '0;
            presc_q   <= '0;
        end else begin
            wst_q     <= wst_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rst_q     <= rst_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            ctrl_q    <= ctrl_d;
            presc_q   <= presc_d;
        end
    end

    led_pwm_core #(
        .NUM_CH  (NUM_CH),
        .PWM_W   (PWM_W),
        .PRESC_W (PRESC_W)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .en        (ctrl_q[CTRL_EN_BIT]),
        .inv       (ctrl_q[CTRL_INV_BIT]),
        .presc     (presc_q),
        .shd_we    (shd_we),
        .shd_wdata (shd_wdata),
        .shd_flat  (shd_flat),
        .cnt       (cnt),
        .wrap      (wrap),
        .led       (led)
    );

    assign s_axil_awready = awready_q;
    assign s_axil_wready  = wready_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_arready = arready_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;

    logic unused_ok;
`ifdef AXIL_LED_PWM_IRQ_EN
    assign unused_ok = ^{s_axil_awprot, s_axil_arprot, wr_addr[1:0], s_axil_araddr[1:0],
                         wr_data, wr_strb, strb_mask};
`else
    assign unused_ok = ^{s_axil_awprot, s_axil_arprot, wr_addr[1:0], s_axil_araddr[1:0],
                         wr_data, wr_strb, strb_mask, wrap};
`endif

endmodule
